// File: rtl/gate_truth_checker.sv
// gate_truth_checker: self-checking stimulus sequencer for a 2-input gate.
// It walks {a,b} through 00,01,10,11. For each vector it waits SETTLE_CYCLES
// cycles, then samples c against a golden truth table chosen by gate_sel.
// It counts mismatches and reports done/pass when the walk is complete.
// Optional feature macro: GATE_CHECK_FIRST_FAIL_EN. When it is defined, the
// first failing vector of a run is captured on first_fail/first_fail_vld.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       gate_sel,
    input  logic             c,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       vec_idx,
    output logic             done,
    output logic             pass,
    output logic [1:0]       first_fail,
    output logic             first_fail_vld
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // The settle counter loads SETTLE_CYCLES-1 and counts down to zero.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Golden 2-input function selected by the latched gate_sel.
    function automatic logic golden(input logic [1:0] sel, input logic va, input logic vb);
        logic g;
        case (sel)
            2'b00:   g = va & vb;
            2'b01:   g = va | vb;
            2'b10:   g = va ^ vb;
            default: g = ~(va & vb);
        endcase
        return g;
    endfunction

    state_t           state_r;
    logic [1:0]       sel_r;
    logic             a_r;
    logic             b_r;
    logic             busy_r;
    logic             mismatch_r;
    logic [ERR_W-1:0] err_count_r;
    logic [1:0]       vec_idx_r;
    logic             done_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic             sample_miss_s;
`ifdef GATE_CHECK_FIRST_FAIL_EN
    logic [1:0]       first_fail_r;
    logic             first_fail_vld_r;
`endif

    // Compare the gate output against the golden value for the current vector.
    always_comb begin
        sample_miss_s = 1'b0;
        if (state_r == S_SAMPLE) begin
            sample_miss_s = (c != golden(sel_r, a_r, b_r));
        end else begin
            sample_miss_s = 1'b0;
        end
    end

    // Sequencer FSM with registered stimulus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            sel_r        <= 2'b00;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            busy_r       <= 1'b0;
            mismatch_r   <= 1'b0;
            err_count_r  <= {ERR_W{1'b0}};
            vec_idx_r    <= 2'd0;
            done_r       <= 1'b0;
            settle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            mismatch_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sel_r       <= gate_sel;
                        err_count_r <= {ERR_W{1'b0}};
                        done_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        vec_idx_r   <= 2'd0;
                        a_r         <= 1'b0;
                        b_r         <= 1'b0;
                        state_r     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (SETTLE_CYCLES > 0) begin
                        settle_cnt_r <= SETTLE_LOAD;
                        state_r      <= S_SETTLE;
                    end else begin
                        state_r <= S_SAMPLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_SAMPLE: begin
                    if (sample_miss_s) begin
                        mismatch_r <= 1'b1;
                        if (err_count_r != ERR_MAX) begin
                            err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    if (vec_idx_r != 2'd3) begin
                        vec_idx_r  <= vec_idx_r + 2'd1;
                        {a_r, b_r} <= vec_idx_r + 2'd1;
                        state_r    <= S_DRIVE;
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GATE_CHECK_FIRST_FAIL_EN
    // Capture the first failing vector of a run; sticky until the next run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_r     <= 2'b00;
            first_fail_vld_r <= 1'b0;
        end else if ((state_r == S_IDLE || state_r == S_DONE) && start) begin
            first_fail_r     <= 2'b00;
            first_fail_vld_r <= 1'b0;
        end else if (sample_miss_s && !first_fail_vld_r) begin
            first_fail_r     <= {a_r, b_r};
            first_fail_vld_r <= 1'b1;
        end
    end

    assign first_fail     = first_fail_r;
    assign first_fail_vld = first_fail_vld_r;
`else
    assign first_fail     = 2'b00;
    assign first_fail_vld = 1'b0;
`endif

    assign a         = a_r;
    assign b         = b_r;
    assign busy      = busy_r;
    assign mismatch  = mismatch_r;
    assign err_count = err_count_r;
    assign vec_idx   = vec_idx_r;
    assign done      = done_r;
    assign pass      = done_r && (err_count_r == {ERR_W{1'b0}});

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker. It uses two instances: one with the default
// settle interval of 2 and one with no settle interval. A per-run model
// predicts every output from the number of clock edges since the accepted
// start. The start edge counts as cycle 1, and the predictions follow from
// vector timing and truth tables. Literal checks pin the model at key points.
module tb_gate_truth_checker;

    localparam int P0 = 4; // cycles per vector, SETTLE_CYCLES=2
    localparam int P1 = 2; // cycles per vector, SETTLE_CYCLES=0

    // Codes for the behaviour of the gate under test (0..3 match gate_sel).
    localparam int G_AND = 0, G_OR = 1, G_XOR = 2, G_NAND = 3, G_ONE = 4;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       mismatch;
        logic [2:0] err;
        logic [1:0] vec;
        logic       done;
        logic       pass;
        logic [1:0] ff;
        logic       ffv;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [1:0] gate_sel0 = 2'b00, gate_sel1 = 2'b00;
    int gut0 = G_AND, gut1 = G_AND;
    logic c0, c1;
    logic a0, b0, busy0, mismatch0, done0, pass0, ffv0;
    logic a1, b1, busy1, mismatch1, done1, pass1, ffv1;
    logic [2:0] err0, err1;
    logic [1:0] vec0, vec1, ff0, ff1;

    int tests = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    int m0_n = 0, m1_n = 0;
    logic [1:0] m0_sel = 2'b00, m1_sel = 2'b00;
    int m0_gut = 0, m1_gut = 0;

    always #5 clk = ~clk;

    // Truth table indexed by {a,b}: bit k is the output for vector k.
    function automatic logic [3:0] tbl(input int code);
        case (code)
            G_AND:   return 4'b1000;
            G_OR:    return 4'b1110;
            G_XOR:   return 4'b0110;
            G_NAND:  return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    assign c0 = tbl(gut0) >> {a0, b0};
    assign c1 = tbl(gut1) >> {a1, b1};

    gate_truth_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .gate_sel(gate_sel0), .c(c0),
        .a(a0), .b(b0), .busy(busy0), .mismatch(mismatch0), .err_count(err0),
        .vec_idx(vec0), .done(done0), .pass(pass0), .first_fail(ff0),
        .first_fail_vld(ffv0));

    gate_truth_checker #(.SETTLE_CYCLES(0), .ERR_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(gate_sel1), .c(c1),
        .a(a1), .b(b1), .busy(busy1), .mismatch(mismatch1), .err_count(err1),
        .vec_idx(vec1), .done(done1), .pass(pass1), .first_fail(ff1),
        .first_fail_vld(ffv1));

    // Expected outputs n edges after an accepted start (n=0: idle/reset).
    function automatic obs_t model(input int p, input int n, input logic [1:0] sel,
                                   input int gut);
        obs_t e;
        logic [3:0] gold, out;
        int k, cnt;
        e = '0;
        if (n == 0) return e;
        gold = tbl(int'(sel));
        out  = tbl(gut);
        if (n <= 4 * p) begin
            k = (n - 1) / p;
            e.busy = 1'b1;
        end else begin
            k = 3;
            e.done = 1'b1;
        end
        e.vec = k[1:0];
        {e.a, e.b} = k[1:0];
        cnt = 0;
        for (int j = 0; j < 4; j++) begin
            if (gold[j] != out[j] && (j + 1) * p + 1 <= n) begin
`ifdef GATE_CHECK_FIRST_FAIL_EN
                if (cnt == 0) begin
                    e.ff  = j[1:0];
                    e.ffv = 1'b1;
                end
`endif
                cnt++;
                if ((j + 1) * p + 1 == n) e.mismatch = 1'b1;
            end
        end
        e.err  = cnt[2:0];
        e.pass = e.done && (cnt == 0);
        return e;
    endfunction

    // Model run tracking for dut0: edges since start, latched sel and gate.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_n <= 0;
        end else if (start0 && (m0_n == 0 || m0_n > 4 * P0)) begin
            m0_n   <= 1;
            m0_sel <= gate_sel0;
            m0_gut <= gut0;
        end else if (m0_n != 0 && m0_n < 4 * P0 + 2) begin
            m0_n <= m0_n + 1;
        end
    end

    // Model run tracking for dut1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_n <= 0;
        end else if (start1 && (m1_n == 0 || m1_n > 4 * P1)) begin
            m1_n   <= 1;
            m1_sel <= gate_sel1;
            m1_gut <= gut1;
        end else if (m1_n != 0 && m1_n < 4 * P1 + 2) begin
            m1_n <= m1_n + 1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        obs_t e, o;
        if (chk_en) begin
            e = model(P0, m0_n, m0_sel, m0_gut);
            o = {a0, b0, busy0, mismatch0, err0, vec0, done0, pass0, ff0, ffv0};
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL model_dut0 t=%0t n=%0d got=%h exp=%h", $time, m0_n, o, e);
            end
            e = model(P1, m1_n, m1_sel, m1_gut);
            o = {a1, b1, busy1, mismatch1, err1, vec1, done1, pass1, ff1, ffv1};
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL model_dut1 t=%0t n=%0d got=%h exp=%h", $time, m1_n, o, e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Run dut0 from the start edge until done. Returns the cycle done was first
    // seen (start edge = 1) and the count of mismatch pulses. A start pulse with
    // a different gate_sel is re-sent at cycle resend_at when that is nonzero.
    task automatic run0(input logic [1:0] sel, input int gut, input int resend_at,
                        output int done_at, output int pulses);
        @(posedge clk); #2;
        gate_sel0 = sel; gut0 = gut; start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        done_at = 1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mismatch0) pulses++;
            if (done0) break;
            @(posedge clk);
            done_at++;
            #2;
            start0 = (done_at + 1 == resend_at);
            if (start0) gate_sel0 = ~sel;
        end
        start0 = 1'b0;
    endtask

    initial begin
        int d, p;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // AND golden, AND gate: clean pass.
        run0(2'b00, G_AND, 0, d, p);
        chk("and_done_cycle", d, 17);
        chk("and_pulses", p, 0);
        chk("and_err", int'(err0), 0);
        chk("and_pass", int'(pass0), 1);
        chk("and_ab_hold", int'({a0, b0}), 3);

        // AND golden, OR gate: vectors 01 and 10 disagree.
        run0(2'b00, G_OR, 0, d, p);
        chk("or_done_cycle", d, 17);
        chk("or_pulses", p, 2);
        chk("or_err", int'(err0), 2);
        chk("or_pass", int'(pass0), 0);
`ifdef GATE_CHECK_FIRST_FAIL_EN
        chk("or_first_fail", int'(ff0), 1);
        chk("or_first_vld", int'(ffv0), 1);
`else
        chk("or_first_fail", int'(ff0), 0);
        chk("or_first_vld", int'(ffv0), 0);
`endif

        // NAND golden, output stuck at 1: only vector 11 disagrees.
        run0(2'b11, G_ONE, 0, d, p);
        chk("stuck_pulses", p, 1);
        chk("stuck_err", int'(err0), 1);
`ifdef GATE_CHECK_FIRST_FAIL_EN
        chk("stuck_first_fail", int'(ff0), 3);
`else
        chk("stuck_first_fail", int'(ff0), 0);
`endif

        // Reset at cycle 6 of a run aborts immediately.
        @(posedge clk); #2;
        gate_sel0 = 2'b00; gut0 = G_AND; start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_vec", int'(vec0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_ab", int'({a0, b0}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run0(2'b00, G_AND, 0, d, p);
        chk("post_rst_done_cycle", d, 17);
        chk("post_rst_pass", int'(pass0), 1);

        // Start re-sent at cycle 5 while busy is ignored.
        run0(2'b00, G_AND, 5, d, p);
        chk("resend_done_cycle", d, 17);
        chk("resend_pass", int'(pass0), 1);

        // XOR golden, XOR gate, after a failing run: counters cleared.
        run0(2'b00, G_OR, 0, d, p);
        chk("pre_xor_err", int'(err0), 2);
        run0(2'b10, G_XOR, 0, d, p);
        chk("xor_err", int'(err0), 0);
        chk("xor_pass", int'(pass0), 1);
        chk("xor_first_vld", int'(ffv0), 0);

        // No settle interval: 2 cycles per vector.
        @(posedge clk); #2;
        gate_sel1 = 2'b00; gut1 = G_AND; start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        d = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done1) break;
            @(posedge clk);
            d++;
        end
        chk("s0_done_cycle", d, 9);
        chk("s0_pass", int'(pass1), 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
